// File: rtl/i2c_pkg.sv
// Shared types and widths for the system-clocked I2C slave register file.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;
  localparam int unsigned BIT_CNT_W  = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one bus pin, with registered level and
// single-clk rise/fall pulses that are aligned with the level output.
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Reset to the idle-bus level so that leaving reset never looks like START.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      level  <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
      fall   <= ~sync_q[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave with an auto-incrementing byte register file, clocked by clk.
// Define I2C_SLAVE_READ_EN to build the read path; otherwise reads are NACKed.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned PTR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  input  logic [I2C_ADDR_W-1:0] slave_addr,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_addr,
  output logic [I2C_BYTE_W-1:0] wr_data,
  input  logic [PTR_W-1:0]      host_rd_addr,
  output logic [I2C_BYTE_W-1:0] host_rd_data,
  output logic                  busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst(rst), .din(scl_i), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst(rst), .din(sda_i), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0]  shreg_q, shreg_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d, ptr_inc_c;
  logic                   sda_oe_d, busy_d, wr_en_c;
  logic                   start_c, stop_c, byte_done_c, rw_ok_c;
  logic [I2C_BYTE_W-1:0]  regs [NUM_REGS];
`ifdef I2C_SLAVE_READ_EN
  logic                   rw_q, rw_d;
  logic [I2C_BYTE_W-1:0]  tx_q, tx_d;
`endif

  // The aligned SCL level already reflects a same-cycle SCL fall, so data
  // changes right after a falling SCL never look like START/STOP.
  assign start_c     = sda_fall & scl_lvl;
  assign stop_c      = sda_rise & scl_lvl;
  assign byte_done_c = scl_fall && (bit_cnt_q == BIT_CNT_W'(I2C_BYTE_W));
  assign ptr_inc_c   = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
`ifdef I2C_SLAVE_READ_EN
  assign rw_ok_c     = 1'b1;
`else
  assign rw_ok_c     = ~shreg_q[0];
`endif

  assign host_rd_data = regs[host_rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      rw_q      <= 1'b0;
      tx_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
`ifdef I2C_SLAVE_READ_EN
      rw_q      <= rw_d;
      tx_q      <= tx_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe;
    busy_d    = busy;
    wr_en_c   = 1'b0;
`ifdef I2C_SLAVE_READ_EN
    rw_d      = rw_q;
    tx_d      = tx_q;
`endif
    if (start_c) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_c) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      if (scl_rise && (state_q inside {ST_ADDR, ST_PTR, ST_WR_DATA})) begin
        shreg_d   = {shreg_q[I2C_BYTE_W-2:0], sda_lvl};
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      end
      case (state_q)
        ST_ADDR: if (byte_done_c) begin
          bit_cnt_d = '0;
          if ((shreg_q[I2C_BYTE_W-1:1] == slave_addr) && rw_ok_c) begin
            state_d  = ST_ADDR_ACK;
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
`ifdef I2C_SLAVE_READ_EN
            rw_d     = shreg_q[0];
`endif
          end else begin
            state_d  = ST_IGNORE;
            sda_oe_d = 1'b0;
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_PTR;
`ifdef I2C_SLAVE_READ_EN
          if (rw_q) begin
            state_d  = ST_RD_DATA;
            tx_d     = regs[ptr_q];
            sda_oe_d = ~regs[ptr_q][I2C_BYTE_W-1];
            ptr_d    = ptr_inc_c;
          end
`endif
        end
        ST_PTR: if (byte_done_c) begin
          bit_cnt_d = '0;
          if ({1'b0, shreg_q} < 9'(NUM_REGS)) begin
            ptr_d    = PTR_W'(shreg_q);
            sda_oe_d = 1'b1;
            state_d  = ST_PTR_ACK;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ST_IGNORE;
          end
        end
        ST_PTR_ACK, ST_WR_ACK: if (scl_fall) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = ST_WR_DATA;
        end
        ST_WR_DATA: if (byte_done_c) begin
          wr_en_c   = 1'b1;
          sda_oe_d  = 1'b1;
          ptr_d     = ptr_inc_c;
          bit_cnt_d = '0;
          state_d   = ST_WR_ACK;
        end
`ifdef I2C_SLAVE_READ_EN
        // bit_cnt counts master sampling edges of the outgoing byte
        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end else if (byte_done_c) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = ST_RD_ACK;
          end else if (scl_fall) begin
            tx_d     = {tx_q[I2C_BYTE_W-2:0], 1'b0};
            sda_oe_d = ~tx_q[I2C_BYTE_W-2];
          end
        end
        // bit_cnt = 1 records a master ACK seen on the ninth SCL rise
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_lvl) state_d = ST_IGNORE;
            else         bit_cnt_d = BIT_CNT_W'(1);
          end else if (scl_fall && (bit_cnt_q == BIT_CNT_W'(1))) begin
            bit_cnt_d = '0;
            state_d   = ST_RD_DATA;
            tx_d      = regs[ptr_q];
            sda_oe_d  = ~regs[ptr_q][I2C_BYTE_W-1];
            ptr_d     = ptr_inc_c;
          end
        end
`endif
        ST_IDLE, ST_IGNORE: ;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
    if ((state_d == ST_IDLE) || (state_d == ST_IGNORE)) busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      wr_strobe <= wr_en_c;
      if (wr_en_c) begin
        wr_addr     <= ptr_q;
        wr_data     <= shreg_q;
        regs[ptr_q] <= shreg_q;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged I2C master on an open-drain SDA model.
module tb_i2c_slave_regfile;

  localparam int unsigned NUM_REGS    = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned PTR_W       = 4;
  localparam int          H           = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             scl;
  logic             sda_m;
  logic             sda_oe;
  logic [6:0]       slave_addr;
  logic             wr_strobe;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic [PTR_W-1:0] host_rd_addr;
  logic [7:0]       host_rd_data;
  logic             busy;
  wire              sda_line = sda_m & ~sda_oe;

  i2c_slave_regfile #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .slave_addr(slave_addr), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int qa[$];
  int qd[$];
  bit oe_seen;
  bit busy_seen;

  always @(negedge clk) begin
    if (wr_strobe) begin
      qa.push_back(int'(wr_addr));
      qd.push_back(int'(wr_data));
    end
    if (sda_oe) oe_seen = 1'b1;
    if (busy)   busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(H);
    scl   = 1'b1; tick(H);
    sda_m = 1'b0; tick(H);
    scl   = 1'b0; tick(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(H);
    scl   = 1'b1; tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sda_m = b[7-i]; tick(H);
      scl   = 1'b1;   tick(H);
      scl   = 1'b0;   tick(2);
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; tick(H);
    ack   = ~sda_line;
    scl   = 1'b1; tick(H);
    scl   = 1'b0; tick(2);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(H);
      scl  = 1'b1; tick(H/2);
      b[i] = sda_line; tick(H/2);
      scl  = 1'b0; tick(2);
    end
    sda_m = ~ack; tick(H);
    scl   = 1'b1; tick(H);
    scl   = 1'b0; tick(2);
    sda_m = 1'b1;
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [7:0] exp);
    host_rd_addr = PTR_W'(idx);
    tick(1);
    check(tag, host_rd_data, exp);
  endtask

  task automatic chk_strobe(input string tag, input int a, input int d);
    if (qa.size() == 0) begin
      check(tag, 32'hFFFF_FFFF, a);
    end else begin
      check({tag, "_addr"}, qa.pop_front(), a);
      check({tag, "_data"}, qd.pop_front(), d);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] rb;
    rst = 1'b1; scl = 1'b1; sda_m = 1'b1; slave_addr = 7'h50; host_rd_addr = '0;
    tick(4);
    rst = 1'b0;
    tick(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    chk_reg("rst_reg3", 3, 8'h00);

    // basic two-byte write
    i2c_start();
    write_byte(8'hA0, ack); check("w_addr_ack", ack, 1);
    check("w_busy", busy, 1);
    write_byte(8'h03, ack); check("w_ptr_ack", ack, 1);
    write_byte(8'hA5, ack); check("w_d0_ack", ack, 1);
    write_byte(8'h3C, ack); check("w_d1_ack", ack, 1);
    i2c_stop();
    tick(4);
    check("w_busy_after_stop", busy, 0);
    check("w_nstrobe", qa.size(), 2);
    chk_strobe("w_s0", 3, 8'hA5);
    chk_strobe("w_s1", 4, 8'h3C);
    chk_reg("w_reg3", 3, 8'hA5);
    chk_reg("w_reg4", 4, 8'h3C);

    // pointer wrap
    i2c_start();
    write_byte(8'hA0, ack); check("wrap_addr_ack", ack, 1);
    write_byte(8'h0F, ack); check("wrap_ptr_ack", ack, 1);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    write_byte(8'h33, ack); check("wrap_d2_ack", ack, 1);
    i2c_stop();
    tick(4);
    check("wrap_nstrobe", qa.size(), 3);
    chk_strobe("wrap_s0", 15, 8'h11);
    chk_strobe("wrap_s1", 0, 8'h22);
    chk_strobe("wrap_s2", 1, 8'h33);
    chk_reg("wrap_reg15", 15, 8'h11);
    chk_reg("wrap_reg0", 0, 8'h22);
    chk_reg("wrap_reg1", 1, 8'h33);

    // address mismatch
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, ack); check("mis_addr_nack", ack, 0);
    write_byte(8'h03, ack); check("mis_ptr_nack", ack, 0);
    write_byte(8'hFF, ack);
    i2c_stop();
    tick(4);
    check("mis_oe_seen", oe_seen, 0);
    check("mis_busy_seen", busy_seen, 0);
    check("mis_nstrobe", qa.size(), 0);
    chk_reg("mis_reg3", 3, 8'hA5);

    // seed reg2, then pointer write + repeated START read
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    write_byte(8'h5A, ack); check("seed_ack", ack, 1);
    i2c_stop();
    tick(4);
    chk_strobe("seed_s0", 2, 8'h5A);

    i2c_start();
    write_byte(8'hA0, ack); check("rd_waddr_ack", ack, 1);
    write_byte(8'h02, ack); check("rd_ptr_ack", ack, 1);
    i2c_start();
    write_byte(8'hA1, ack);
`ifdef I2C_SLAVE_READ_EN
    check("rd_raddr_ack", ack, 1);
    read_byte(1'b1, rb); check("rd_byte0", rb, 8'h5A);
    read_byte(1'b0, rb); check("rd_byte1", rb, 8'hA5);
    tick(H);
    check("rd_released", sda_oe, 0);
    check("rd_busy_nack", busy, 0);
`else
    check("rd_raddr_nack", ack, 0);
    tick(4);
    check("rd_busy_nack", busy, 0);
    check("rd_released", sda_oe, 0);
`endif
    i2c_stop();
    tick(4);
    check("rd_nstrobe", qa.size(), 0);

    // out-of-range pointer
    i2c_start();
    write_byte(8'hA0, ack); check("bp_addr_ack", ack, 1);
    write_byte(8'h14, ack); check("bp_ptr_nack", ack, 0);
    write_byte(8'h77, ack); check("bp_data_nack", ack, 0);
    i2c_stop();
    tick(4);
    check("bp_nstrobe", qa.size(), 0);
    chk_reg("bp_reg4", 4, 8'h3C);
    chk_reg("bp_reg0", 0, 8'h22);

    // STOP after four data bits
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack); check("ps_ptr_ack", ack, 1);
    send_bits(8'hF0, 4);
    i2c_stop();
    tick(4);
    check("ps_nstrobe", qa.size(), 0);
    check("ps_sda_oe", sda_oe, 0);
    check("ps_busy", busy, 0);
    chk_reg("ps_reg5", 5, 8'h00);

    // reset mid-byte, then a fresh write from pointer 0
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h06, ack);
    send_bits(8'hC3, 4);
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(1);
    check("rr_sda_oe", sda_oe, 0);
    check("rr_busy", busy, 0);
    chk_reg("rr_reg3", 3, 8'h00);
    i2c_stop();
    tick(4);
    check("rr_nstrobe", qa.size(), 0);
    i2c_start();
    write_byte(8'hA0, ack); check("rr_addr_ack", ack, 1);
    write_byte(8'h00, ack); check("rr_ptr_ack", ack, 1);
    write_byte(8'h99, ack); check("rr_d0_ack", ack, 1);
    i2c_stop();
    tick(4);
    chk_strobe("rr_s0", 0, 8'h99);
    chk_reg("rr_reg0", 0, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised, system-clocked I2C slave with an internal byte register file. It oversamples SCL/SDA, detects START, repeated START and STOP, and matches a 7-bit address. It supports multi-byte writes and reads with an auto-incrementing register pointer and reports each register write to the fabric. It supersedes the SCL-clocked single-byte slave and sits between the board I2C pins (via an open-drain pad) and local control logic.

## Interface
- NUM_REGS, 16: register file depth, 2..256; pointer width PTR_W = clog2(NUM_REGS).
- SYNC_STAGES, 2: synchroniser flops on SCL and SDA, ≥2.
- clk  in  1  system clock; only clock in the block.
- rst  in  1  reset; one clock, synchronous, active-high.
- scl_i  in  1  SCL pin level.
- sda_i  in  1  SDA pin level.
- sda_oe  out  1  1 = pull SDA low; 0 = release (pad drives 'z').
- slave_addr  in  7  own address; sampled when the address byte completes.
- wr_strobe  out  1  one-clk pulse per register written over I2C.
- wr_addr  out  PTR_W  register index of the last write.
- wr_data  out  8  byte of the last write.
- host_rd_addr  in  PTR_W  fabric read index.
- host_rd_data  out  8  reg[host_rd_addr], combinational.
- busy  out  1  1 from addressed START until STOP or mismatch.

## Operation
- Edges are taken from the synchronised signals only. START = SDA falls while SCL is high. STOP = SDA rises while SCL is high. Data bits are sampled on SCL rise and SDA is changed on SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first.
  - ADDR_ACK.
  - PTR: 8 bits.
  - PTR_ACK.
  - WR_DATA: 8 bits.
  - WR_ACK.
  - RD_DATA: drive 8 bits.
  - RD_ACK: sample master ACK/NACK.
  - IGNORE: released until START or STOP.
- Address match: byte[7:1] == slave_addr. On mismatch go to IGNORE with sda_oe = 0 throughout.
- Write transaction (R/W = 0): the first data byte loads the pointer. If the pointer is ≥ NUM_REGS, NACK and go to IGNORE. Every following byte writes reg[ptr] and is ACKed, then ptr increments.
- Read transaction (R/W = 1): shift out reg[ptr] MSB first, then ptr increments. A master ACK loads the next byte. A master NACK releases SDA and goes to IGNORE.
- Pointer increments wrap from NUM_REGS-1 to 0. The pointer persists across transactions until reset, so a write-pointer, repeated START, read sequence reads from the written pointer.
- Repeated START in any state returns to ADDR with the bit counter cleared. STOP in any state returns to IDLE and releases SDA. A partially received byte is discarded and reg is not written.
- Simultaneous host_rd_addr read and I2C write to the same register: host_rd_data shows the old value until the write clk, then the new value.

## Timing
- Reset values: sda_oe 0, wr_strobe 0, wr_addr 0, wr_data 0, busy 0, all regs 0x00, ptr 0, state IDLE.
- Pin-to-event latency is SYNC_STAGES+1 clk. sda_oe updates 1 clk after the detected SCL fall.
- Register write happens on the detected SCL fall ending bit 8 of a data byte. In that same clk: reg[ptr] updates, wr_strobe pulses, wr_addr/wr_data update, and the ACK is asserted on sda_oe. The ACK is held until the next detected SCL fall.
- Read byte load happens on the detected SCL fall ending ADDR_ACK or an ACKed RD_ACK.
- Required bus timing: SCL high and low phases each ≥ SYNC_STAGES+3 clk. No clock stretching.
- busy rises with ADDR_ACK (matched address) and falls the clk after STOP or IGNORE entry.
- rst mid-transfer releases SDA in the next clk, and the block ignores the bus until a fresh START.

## Configuration
- I2C_SLAVE_READ_EN defined: read path built (RD_DATA/RD_ACK states, output shifter).
- I2C_SLAVE_READ_EN undefined: a matched address with R/W = 1 is NACKed at ADDR_ACK and the block goes to IGNORE. The read states and shifter are not synthesised. The write path and host_rd port are unchanged.

## Structure
- Package i2c_pkg: state enum, I2C_ADDR_W = 7, I2C_BYTE_W = 8, bit-count width.
- Sub-module i2c_sync_edge: SYNC_STAGES flop synchroniser plus rise/fall pulse outputs. Instantiated for SCL and for SDA.
- Top level holds the FSM, shifter, pointer and register array.

## Test plan
- Write 0x50 (slave_addr 0x50), ptr 0x03, data 0xA5, 0x3C, STOP -> both bytes ACKed; reg3 = 0xA5, reg4 = 0x3C; two wr_strobe pulses with wr_addr 3 then 4.
- Write ptr 0x0F then 3 bytes (NUM_REGS = 16) -> regs 15, 0, 1 written (pointer wrap).
- Address 0x51 with slave_addr 0x50 -> sda_oe never asserted, busy stays 0, no writes.
- Write ptr 0x02, repeated START, read 2 bytes with ACK then NACK -> SDA returns reg2 then reg3; released after NACK. Without I2C_SLAVE_READ_EN: read address is NACKed.
- Write ptr 0x14 (≥16) -> NACK on the pointer byte; following bytes ignored; reg contents unchanged.
- STOP after 4 data bits, and separately rst asserted mid-byte -> no register write, sda_oe 0, next transaction at ptr 0x00 after rst succeeds.
